spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter RX_DEPTH, default 4, RX FIFO depth in bytes (power of two, 2..16).
REQ-002 SHALL have ports:
  clk  input  1  system clock, all logic on rising edge
  resetn  input  1  asynchronous active-low reset
  ctrl_wr  input  1  register write request
  ctrl_rd  input  1  register read request
  ctrl_addr  input  8  register byte address
  ctrl_wdat  input  32  write data
  ctrl_rdat  output  32  read data, valid when ctrl_done=1
  ctrl_done  output  1  one-cycle access completion pulse
  cs_n  input  1  SPI chip select from master, active low
  sclk  input  1  SPI clock from master
  mosi  input  1  master-out data
  miso  output  1  slave-out data
  miso_oe  output  1  miso output enable (1 only while selected)
  irq  output  1  interrupt (present only with SPI_SLAVE_IRQ_EN)
REQ-003 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 Registers: 0x00 STATUS, 0x04 RXDATA, 0x08 TXDATA, 0x0C MODE {cpol=bit1, cpha=bit0}.
REQ-005 STATUS read: bit0 rx_valid, bit1 tx_empty, bit2 overrun (sticky), bit3 selected, bits[7:4] rx_count, rest 0; writing bit2=1 clears overrun.
REQ-006 Access with ctrl_wr or ctrl_rd SHALL complete with ctrl_done=1 the following cycle; requests seen while ctrl_done=1 SHALL be ignored (no double access).
REQ-007 RXDATA read SHALL return head byte zero-extended and pop; when empty SHALL return 0 without pop. Unknown addresses read 0, writes ignored.
REQ-008 TXDATA write SHALL load ctrl_wdat[7:0] into holding register and clear tx_empty; write when full SHALL overwrite.
REQ-009 cs_n, sclk, mosi SHALL pass 2-FF synchronizers; sclk edges detected from synchronized value; supported sclk <= clk/8.
REQ-010 On synchronized cs_n falling: latch MODE into active mode, bit_cnt=0, miso_oe=1, shifter loaded from holding (set tx_empty) or 0xFF if tx_empty.
REQ-011 Leading edge = sclk leaving cpol level. cpha=0: sample mosi on leading, shift miso on trailing, shifter[7] driven from select. cpha=1: shift miso on leading, sample on trailing.
REQ-012 Bytes MSB first; after 8th sample, received byte SHALL push into RX FIFO and shifter reload per REQ-010 rule in the same cycle.
REQ-013 Push when FIFO full SHALL drop byte and set overrun; push and pop same cycle when full SHALL accept push, no overrun, count unchanged.
REQ-014 TXDATA write same cycle as byte reload: reload takes prior holding state, new data stored in holding afterward.
REQ-015 Synchronized cs_n rising SHALL discard partial byte, set bit_cnt=0, miso_oe=0; miso SHALL be 0 when miso_oe=0.
REQ-016 MODE writes during selection SHALL take effect at next cs_n falling.

Reset
REQ-017 On resetn=0: ctrl_done=0, ctrl_rdat=0, miso=0, miso_oe=0, irq=0, FIFO empty, tx_empty=1, holding=0, overrun=0, MODE=2'b11, bit_cnt=0, synchronizers to idle (cs_n=1, sclk=1).
REQ-018 Reset mid-byte SHALL abandon the transfer; after release, no transfer starts until a fresh synchronized cs_n falling edge.

Configuration
REQ-019 With SPI_SLAVE_IRQ_EN defined: irq SHALL be registered, equal (rx_valid | overrun), one cycle after the underlying flag changes; STATUS bit8 SHALL mirror irq.
REQ-020 Without SPI_SLAVE_IRQ_EN: irq port and logic absent, STATUS bit8 reads 0.

Verification
REQ-021 Mode 3, TXDATA=0xA5, master sends 0x3C -> master receives 0xA5, RXDATA reads 0x3C, then STATUS rx_valid=0.
REQ-022 Mode 0, tx_empty, master sends 0x81,0x42 -> master receives 0xFF,0xFF, RXDATA reads 0x81 then 0x42.
REQ-023 RX_DEPTH=4, master sends 5 bytes unread -> rx_count=4, overrun=1, reads return bytes 1-4; write STATUS 0x4 -> overrun=0.
REQ-024 cs_n raised after 4 bits of 0xF0 -> FIFO empty, miso_oe=0; next full byte 0x12 reads back 0x12.
REQ-025 resetn pulsed low mid-byte -> all REQ-017 values within one cycle; next select transfer correct.
REQ-026 SPI_SLAVE_IRQ_EN defined, one byte received -> irq=1; RXDATA read -> irq=0 next cycle.

Source files
------------

// File: rtl/spi_slave.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_slave
//
// SPI slave with a small register interface. Received bytes go into an RX
// FIFO. One transmit byte waits in a holding register and is copied into the
// shift register when the master selects the slave, and again at every byte
// boundary. When no byte is pending, 0xFF is sent.
//
// Optional feature: define SPI_SLAVE_IRQ_EN to add the irq output. irq is a
// registered copy of (rx_valid | overrun) and is mirrored in STATUS bit 8.
//
// Parameters
//   RX_DEPTH   RX FIFO depth in bytes (power of two, 2..16)
//
// Ports
//   clk        system clock, all logic on rising edge
//   resetn     asynchronous active-low reset
//   ctrl_wr    register write request
//   ctrl_rd    register read request
//   ctrl_addr  register byte address
//                0x00 STATUS, 0x04 RXDATA, 0x08 TXDATA, 0x0C MODE
//   ctrl_wdat  write data
//   ctrl_rdat  read data, valid while ctrl_done=1
//   ctrl_done  one-cycle completion pulse for an accepted access
//   cs_n       SPI chip select from master, active low
//   sclk       SPI clock from master (at most clk/8)
//   mosi       master-out data
//   miso       slave-out data, forced to 0 while not selected
//   miso_oe    miso output enable, 1 only while selected
//   irq        interrupt (only with SPI_SLAVE_IRQ_EN)
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ctrl_wr,
  input  logic        ctrl_rd,
  input  logic [7:0]  ctrl_addr,
  input  logic [31:0] ctrl_wdat,
  output logic [31:0] ctrl_rdat,
  output logic        ctrl_done,
  input  logic        cs_n,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe
`ifdef SPI_SLAVE_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(RX_DEPTH);

  localparam logic [7:0] ADDR_STATUS = 8'h00;
  localparam logic [7:0] ADDR_RXDATA = 8'h04;
  localparam logic [7:0] ADDR_TXDATA = 8'h08;
  localparam logic [7:0] ADDR_MODE   = 8'h0C;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } xfer_state_t;

  // The STATUS count field is 4 bits wide. A full 16-deep FIFO reads back as 15.
  function automatic logic [3:0] count_field(input logic [4:0] cnt);
    logic [3:0] f;
    if (cnt > 5'd15) begin
      f = 4'hF;
    end else begin
      f = cnt[3:0];
    end
    return f;
  endfunction

  // synchronizers and edge detection
  logic       cs_meta_r, cs_sync_r, cs_prev_r;
  logic       sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic       mosi_meta_r, mosi_sync_r;
  logic [1:0] sync_fill_r;
  logic       cs_fall_s, cs_rise_s, sclk_rise_s, sclk_fall_s;
  logic       lead_s, trail_s;

  // transfer control
  xfer_state_t state_r, state_s;
  logic        start_s, stop_s, sample_s, shift_s, byte_done_s, reload_s;
  logic [1:0]  act_mode_r;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  rx_shift_r, tx_shift_r, reload_byte_s, rx_byte_s;
  logic        miso_r, miso_oe_r;

  // register file
  logic [1:0]  mode_r;
  logic [7:0]  holding_r;
  logic        tx_empty_r, overrun_r;
  logic        ctrl_done_r;
  logic [31:0] ctrl_rdat_r, rd_val_s, status_s;
  logic        acc_rd_s, acc_wr_s, irq_bit_s;

  // RX FIFO
  logic [7:0]    rx_mem_r [RX_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] rx_count_r;
  logic          rx_valid_s, full_s, push_s, push_ok_s, pop_s;
  logic [7:0]    rx_head_s;

  // ctrl_wdat carries only an 8-bit payload
  logic unused_wdat_s;
  assign unused_wdat_s = ^ctrl_wdat[31:8];

  // Two-flop synchronizers with idle-bus reset values (cs_n=1, sclk=1).
  // sync_fill_r marks when the synchronizer holds real pin samples. Until
  // then, cs_prev_r stays 0. If cs_n is held low through reset, this blocks
  // a false falling edge after release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cs_meta_r   <= 1'b1;
      cs_sync_r   <= 1'b1;
      sclk_meta_r <= 1'b1;
      sclk_sync_r <= 1'b1;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
      sync_fill_r <= 2'b00;
      cs_prev_r   <= 1'b0;
      sclk_prev_r <= 1'b1;
    end else begin
      cs_meta_r   <= cs_n;
      cs_sync_r   <= cs_meta_r;
      sclk_meta_r <= sclk;
      sclk_sync_r <= sclk_meta_r;
      mosi_meta_r <= mosi;
      mosi_sync_r <= mosi_meta_r;
      sync_fill_r <= {sync_fill_r[0], 1'b1};
      cs_prev_r   <= cs_sync_r & sync_fill_r[1];
      sclk_prev_r <= sclk_sync_r;
    end
  end

  assign cs_fall_s   = cs_prev_r & ~cs_sync_r;
  assign cs_rise_s   = ~cs_prev_r & cs_sync_r;
  assign sclk_rise_s = ~sclk_prev_r & sclk_sync_r;
  assign sclk_fall_s = sclk_prev_r & ~sclk_sync_r;
  // leading edge = sclk leaving its idle (cpol) level
  assign lead_s      = act_mode_r[1] ? sclk_fall_s : sclk_rise_s;
  assign trail_s     = act_mode_r[1] ? sclk_rise_s : sclk_fall_s;

  // Selection state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and per-cycle transfer strobes
  always_comb begin
    state_s  = state_r;
    start_s  = 1'b0;
    stop_s   = 1'b0;
    sample_s = 1'b0;
    shift_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_s = ST_ACTIVE;
          start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise_s) begin
          state_s = ST_IDLE;
          stop_s  = 1'b1;
        end else begin
          state_s = ST_ACTIVE;
          if (act_mode_r[0]) begin
            sample_s = trail_s;
            shift_s  = lead_s;
          end else begin
            sample_s = lead_s;
            // In cpha=0 the next byte's MSB is already on miso once a byte
            // completes, so skip the trailing edge that follows the last sample.
            shift_s  = trail_s & (bit_cnt_r != 3'd0);
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign byte_done_s   = sample_s & (bit_cnt_r == 3'd7);
  assign rx_byte_s     = {rx_shift_r[6:0], mosi_sync_r};
  assign reload_s      = start_s | byte_done_s;
  assign reload_byte_s = tx_empty_r ? 8'hFF : holding_r;

  // Shift registers, bit counter, and the registered miso / miso_oe pins
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      act_mode_r <= 2'b11;
      bit_cnt_r  <= 3'd0;
      rx_shift_r <= 8'h00;
      tx_shift_r <= 8'h00;
      miso_r     <= 1'b0;
      miso_oe_r  <= 1'b0;
    end else if (start_s) begin
      act_mode_r <= mode_r;
      bit_cnt_r  <= 3'd0;
      miso_oe_r  <= 1'b1;
      tx_shift_r <= reload_byte_s;
      miso_r     <= reload_byte_s[7];
    end else if (stop_s) begin
      bit_cnt_r  <= 3'd0;
      miso_oe_r  <= 1'b0;
      miso_r     <= 1'b0;
    end else begin
      if (sample_s) begin
        rx_shift_r <= rx_byte_s;
        bit_cnt_r  <= bit_cnt_r + 3'd1;
        if (byte_done_s) begin
          tx_shift_r <= reload_byte_s;
          miso_r     <= reload_byte_s[7];
        end
      end
      if (shift_s) begin
        // cpha=1 presents the current MSB at the leading edge.
        // cpha=0 already shows the MSB, so it moves on to the next bit.
        miso_r     <= act_mode_r[0] ? tx_shift_r[7] : tx_shift_r[6];
        tx_shift_r <= {tx_shift_r[6:0], 1'b0};
      end
    end
  end

  assign acc_rd_s = ctrl_rd & ~ctrl_done_r;
  assign acc_wr_s = ctrl_wr & ~ctrl_done_r;

  // RX FIFO flags and handshakes. A push into a full FIFO succeeds only when
  // a pop happens in the same cycle.
  assign rx_valid_s = (rx_count_r != {CW{1'b0}});
  assign full_s     = (rx_count_r == CNT_FULL);
  assign push_s     = byte_done_s;
  assign push_ok_s  = push_s & (~full_s | pop_s);
  assign pop_s      = acc_rd_s & (ctrl_addr == ADDR_RXDATA) & rx_valid_s;
  assign rx_head_s  = rx_valid_s ? rx_mem_r[rd_ptr_r] : 8'h00;

  // RX FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < RX_DEPTH; i++) begin
        rx_mem_r[i] <= 8'h00;
      end
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      rx_count_r <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        rx_mem_r[wr_ptr_r] <= rx_byte_s;
        wr_ptr_r           <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_s})
        2'b10:   rx_count_r <= rx_count_r + CNT_ONE;
        2'b01:   rx_count_r <= rx_count_r - CNT_ONE;
        default: rx_count_r <= rx_count_r;
      endcase
    end
  end

  // Holding register and tx_empty. A reload reads the old holding value.
  // A TXDATA write in the same cycle is applied after the reload, so the
  // write wins for tx_empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      holding_r  <= 8'h00;
      tx_empty_r <= 1'b1;
    end else begin
      if (reload_s) begin
        tx_empty_r <= 1'b1;
      end
      if (acc_wr_s && (ctrl_addr == ADDR_TXDATA)) begin
        holding_r  <= ctrl_wdat[7:0];
        tx_empty_r <= 1'b0;
      end
    end
  end

  // MODE register and sticky overrun. A new overrun in the same cycle as a
  // clear wins, so the event is not lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_r    <= 2'b11;
      overrun_r <= 1'b0;
    end else begin
      if (acc_wr_s && (ctrl_addr == ADDR_MODE)) begin
        mode_r <= ctrl_wdat[1:0];
      end
      if (push_s && full_s && !pop_s) begin
        overrun_r <= 1'b1;
      end else if (acc_wr_s && (ctrl_addr == ADDR_STATUS) && ctrl_wdat[2]) begin
        overrun_r <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_IRQ_EN
  logic irq_r;

  // Interrupt follows the flags with one cycle of latency
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= rx_valid_s | overrun_r;
    end
  end

  assign irq_bit_s = irq_r;
  assign irq       = irq_r;
`else
  assign irq_bit_s = 1'b0;
`endif

  assign status_s = {23'h0, irq_bit_s, count_field(5'(rx_count_r)),
                     (state_r == ST_ACTIVE), overrun_r, tx_empty_r, rx_valid_s};

  // Read mux. TXDATA is write-only and reads back as 0.
  always_comb begin
    rd_val_s = 32'h0;
    case (ctrl_addr)
      ADDR_STATUS: rd_val_s = status_s;
      ADDR_RXDATA: rd_val_s = {24'h0, rx_head_s};
      ADDR_MODE:   rd_val_s = {30'h0, mode_r};
      default:     rd_val_s = 32'h0;
    endcase
  end

  // Access completion. A request seen while ctrl_done is high is dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_done_r <= 1'b0;
      ctrl_rdat_r <= 32'h0;
    end else begin
      ctrl_done_r <= acc_rd_s | acc_wr_s;
      ctrl_rdat_r <= acc_rd_s ? rd_val_s : 32'h0;
    end
  end

  assign ctrl_done = ctrl_done_r;
  assign ctrl_rdat = ctrl_rdat_r;
  assign miso      = miso_r;
  assign miso_oe   = miso_oe_r;

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
// Self-checking bench for spi_slave. The bench records the bytes the master
// should receive and the bytes RXDATA should return in queues, at the time
// it drives the matching stimulus. It pops and compares them when the DUT
// produces them.
module tb_spi_slave;

  localparam int H = 8;  // sclk half period in clk cycles (sclk = clk/16)
  localparam logic [7:0] A_STATUS = 8'h00;
  localparam logic [7:0] A_RXDATA = 8'h04;
  localparam logic [7:0] A_TXDATA = 8'h08;
  localparam logic [7:0] A_MODE   = 8'h0C;
`ifdef SPI_SLAVE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        ctrl_wr, ctrl_rd;
  logic [7:0]  ctrl_addr;
  logic [31:0] ctrl_wdat, ctrl_rdat;
  logic        ctrl_done;
  logic        cs_n, sclk, mosi, miso, miso_oe;
`ifdef SPI_SLAVE_IRQ_EN
  logic        irq;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] miso_q[$];
  logic [7:0] rx_q[$];
  logic [1:0] cur_mode;

  always #5 clk = ~clk;

  spi_slave #(.RX_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .ctrl_wr(ctrl_wr), .ctrl_rd(ctrl_rd), .ctrl_addr(ctrl_addr),
    .ctrl_wdat(ctrl_wdat), .ctrl_rdat(ctrl_rdat), .ctrl_done(ctrl_done),
    .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
`ifdef SPI_SLAVE_IRQ_EN
    , .irq(irq)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // expected STATUS word; irq (bit 8) follows rx_valid|overrun when enabled
  function automatic logic [31:0] st(input bit rxv, input bit txe, input bit ovr,
                                     input bit sel, input logic [3:0] cnt);
    return {23'h0, (IRQ_EN & (rxv | ovr)), cnt, sel, ovr, txe, rxv};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    ctrl_addr = a; ctrl_wdat = d; ctrl_wr = 1'b1;
    @(negedge clk);
    ctrl_wr = 1'b0;
    chk("wr_done", 32'(ctrl_done), 32'h1);
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    ctrl_addr = a; ctrl_rd = 1'b1;
    @(negedge clk);
    ctrl_rd = 1'b0;
    chk("rd_done", 32'(ctrl_done), 32'h1);
    d = ctrl_rdat;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    reg_read(a, d);
    chk(tag, d, exp);
  endtask

  // pop the next expected RX byte and compare with an RXDATA read
  task automatic rx_pop_chk();
    logic [31:0] d, exp;
    reg_read(A_RXDATA, d);
    exp = (rx_q.size() > 0) ? {24'h0, rx_q.pop_front()} : 32'hDEAD_BEEF;
    chk("rxdata", d, exp);
  endtask

  task automatic spi_select(input logic [1:0] m);
    cur_mode = m;
    sclk = m[1];
    wait_clk(H);
    cs_n = 1'b0;
    wait_clk(H);
  endtask

  task automatic spi_deselect();
    wait_clk(H);
    cs_n = 1'b1;
    sclk = cur_mode[1];
    wait_clk(H);
  endtask

  // master side of n bits, MSB first
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      if (!cur_mode[0]) begin
        mosi = tx[i];
        wait_clk(H);
        rx[i] = miso;
        sclk = ~cur_mode[1];
        wait_clk(H);
        sclk = cur_mode[1];
      end else begin
        wait_clk(H);
        sclk = ~cur_mode[1];
        mosi = tx[i];
        wait_clk(H);
        rx[i] = miso;
        sclk = cur_mode[1];
      end
    end
  endtask

  // full byte; 'stored' says whether the slave should keep it in its FIFO
  task automatic send_byte(input logic [7:0] tx, input bit stored);
    logic [7:0] r;
    logic [31:0] exp;
    if (stored) rx_q.push_back(tx);
    spi_bits(tx, 8, r);
    exp = (miso_q.size() > 0) ? {24'h0, miso_q.pop_front()} : 32'hDEAD_BEEF;
    chk("miso_byte", {24'h0, r}, exp);
  endtask

  initial begin
    logic [7:0] junk;
    resetn = 1'b0; ctrl_wr = 1'b0; ctrl_rd = 1'b0; ctrl_addr = 8'h00; ctrl_wdat = 32'h0;
    cs_n = 1'b1; sclk = 1'b1; mosi = 1'b0; cur_mode = 2'b11;
    wait_clk(3);

    // reset values
    chk("rst_done", 32'(ctrl_done), 32'h0);
    chk("rst_rdat", ctrl_rdat, 32'h0);
    chk("rst_miso", 32'(miso), 32'h0);
    chk("rst_oe", 32'(miso_oe), 32'h0);
`ifdef SPI_SLAVE_IRQ_EN
    chk("rst_irq", 32'(irq), 32'h0);
`endif
    resetn = 1'b1;
    wait_clk(4);
    read_chk("rst_status", A_STATUS, st(0, 1, 0, 0, 4'd0));
    read_chk("rst_mode", A_MODE, 32'h3);

    // mode 3, TX 0xA5, master sends 0x3C
    reg_write(A_TXDATA, 32'h0000_00A5);
    miso_q.push_back(8'hA5);
    spi_select(2'b11);
    chk("sel_oe", 32'(miso_oe), 32'h1);
    send_byte(8'h3C, 1'b1);
    spi_deselect();
    chk("desel_oe", 32'(miso_oe), 32'h0);
    chk("desel_miso", 32'(miso), 32'h0);
    rx_pop_chk();
    read_chk("m3_status", A_STATUS, st(0, 1, 0, 0, 4'd0));

    // mode 0, nothing pending: 0xFF goes out twice
    reg_write(A_MODE, 32'h0);
    miso_q.push_back(8'hFF); miso_q.push_back(8'hFF);
    spi_select(2'b00);
    send_byte(8'h81, 1'b1);
    send_byte(8'h42, 1'b1);
    spi_deselect();
    rx_pop_chk();
    rx_pop_chk();
    read_chk("rx_empty_read", A_RXDATA, 32'h0);

    // overflow: 5 bytes into a 4-deep FIFO
    for (int k = 0; k < 5; k++) miso_q.push_back(8'hFF);
    spi_select(2'b00);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b0);
    spi_deselect();
    read_chk("ovr_status", A_STATUS, st(1, 1, 1, 0, 4'd4));
    for (int k = 0; k < 4; k++) rx_pop_chk();
    read_chk("ovr_sticky", A_STATUS, st(0, 1, 1, 0, 4'd0));
    reg_write(A_STATUS, 32'h4);
    read_chk("ovr_clear", A_STATUS, st(0, 1, 0, 0, 4'd0));

    // partial byte discarded on deselect, then a full byte
    spi_select(2'b00);
    spi_bits(8'hF0, 4, junk);
    spi_deselect();
    chk("part_oe", 32'(miso_oe), 32'h0);
    read_chk("part_status", A_STATUS, st(0, 1, 0, 0, 4'd0));
    miso_q.push_back(8'hFF);
    spi_select(2'b00);
    send_byte(8'h12, 1'b1);
    spi_deselect();
    rx_pop_chk();

    // mode 1: a second TXDATA write overwrites; a MODE write while selected
    // does not affect the current selection
    reg_write(A_MODE, 32'h1);
    reg_write(A_TXDATA, 32'h11);
    reg_write(A_TXDATA, 32'h5A);
    miso_q.push_back(8'h5A); miso_q.push_back(8'hFF);
    spi_select(2'b01);
    send_byte(8'h0F, 1'b1);
    reg_write(A_MODE, 32'h3);
    read_chk("sel_status", A_STATUS, st(1, 1, 0, 1, 4'd1));
    send_byte(8'hF0, 1'b1);
    spi_deselect();
    read_chk("mode_reg", A_MODE, 32'h3);
    rx_pop_chk();
    rx_pop_chk();

    // reset in the middle of a byte
    spi_select(2'b11);
    spi_bits(8'hAA, 3, junk);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_done", 32'(ctrl_done), 32'h0);
    chk("mid_rst_rdat", ctrl_rdat, 32'h0);
    chk("mid_rst_miso", 32'(miso), 32'h0);
    chk("mid_rst_oe", 32'(miso_oe), 32'h0);
`ifdef SPI_SLAVE_IRQ_EN
    chk("mid_rst_irq", 32'(irq), 32'h0);
`endif
    cs_n = 1'b1; sclk = 1'b1;
    wait_clk(3);
    resetn = 1'b1;
    wait_clk(4);
    read_chk("post_rst_status", A_STATUS, st(0, 1, 0, 0, 4'd0));
    read_chk("post_rst_mode", A_MODE, 32'h3);
    reg_write(A_TXDATA, 32'hC3);
    miso_q.push_back(8'hC3);
    spi_select(2'b11);
    send_byte(8'h99, 1'b1);
    spi_deselect();
    rx_pop_chk();

    // irq follows rx_valid
    miso_q.push_back(8'hFF);
    spi_select(2'b11);
    send_byte(8'h77, 1'b1);
    spi_deselect();
`ifdef SPI_SLAVE_IRQ_EN
    chk("irq_set", 32'(irq), 32'h1);
`endif
    rx_pop_chk();
`ifdef SPI_SLAVE_IRQ_EN
    chk("irq_hold", 32'(irq), 32'h1);
    @(negedge clk);
    chk("irq_clear", 32'(irq), 32'h0);
`endif
    read_chk("final_status", A_STATUS, st(0, 1, 0, 0, 4'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
